// File: rtl/execute_pipe_if.sv
// rtl/execute_pipe_if.sv - RS issue / CDB result bundle and op encodings for execute_pipe
`ifndef EXECUTE_PIPE_OPS
`define EXECUTE_PIPE_OPS
`define Jump     1'b1
`define NotJump  1'b0
`define OP_LUI   6'd1
`define OP_AUIPC 6'd2
`define OP_JAL   6'd3
`define OP_JALR  6'd4
`define OP_BEQ   6'd5
`define OP_BNE   6'd6
`define OP_BLT   6'd7
`define OP_BGE   6'd8
`define OP_BLTU  6'd9
`define OP_BGEU  6'd10
`define OP_ADDI  6'd19
`define OP_SLTI  6'd20
`define OP_SLTIU 6'd21
`define OP_XORI  6'd22
`define OP_ORI   6'd23
`define OP_ANDI  6'd24
`define OP_SLLI  6'd25
`define OP_SRLI  6'd26
`define OP_SRAI  6'd27
`define OP_ADD   6'd28
`define OP_SUB   6'd29
`define OP_SLL   6'd30
`define OP_SLT   6'd31
`define OP_SLTU  6'd32
`define OP_XOR   6'd33
`define OP_SRL   6'd34
`define OP_SRA   6'd35
`define OP_OR    6'd36
`define OP_AND   6'd37
`endif

interface execute_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NICK_W = 4,
  parameter int OP_W   = 6
);
  logic              iRS_en;
  logic              oRS_ready;
  logic [DATA_W-1:0] iRS_pc;
  logic [OP_W-1:0]   iRS_op;
  logic [DATA_W-1:0] iRS_imm;
  logic [NICK_W-1:0] iRS_rd_nick;
  logic [DATA_W-1:0] iRS_rs1_dt;
  logic [DATA_W-1:0] iRS_rs2_dt;
  logic              oEX_en;
  logic              iCDB_gnt;
  logic [NICK_W-1:0] oEX_nick;
  logic [DATA_W-1:0] oEX_dt;
  logic              oEX_ac;
  logic [DATA_W-1:0] oEX_j_pc;

  // RS + CDB arbiter side
  modport master (
    output iRS_en, iRS_pc, iRS_op, iRS_imm, iRS_rd_nick, iRS_rs1_dt, iRS_rs2_dt, iCDB_gnt,
    input  oRS_ready, oEX_en, oEX_nick, oEX_dt, oEX_ac, oEX_j_pc
  );

  // execute unit side
  modport slave (
    input  iRS_en, iRS_pc, iRS_op, iRS_imm, iRS_rd_nick, iRS_rs1_dt, iRS_rs2_dt, iCDB_gnt,
    output oRS_ready, oEX_en, oEX_nick, oEX_dt, oEX_ac, oEX_j_pc
  );
endinterface

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - one-stage integer execute unit with result queue and flush
module execute_pipe #(
  parameter int DATA_W = 32,
  parameter int NICK_W = 4,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         iROB_clr,
  execute_pipe_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);
  localparam logic [PTR_W:0]    FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] ex_dt, ex_jpc, opb, pc4, pc_imm;
  logic              ex_ac, use_imm, lt_s, lt_u, eq;
  logic [SH_W-1:0]   shamt;

  logic              s1_valid_q, s1_valid_d, s1_ac_q, s1_ac_d;
  logic [NICK_W-1:0] s1_nick_q, s1_nick_d;
  logic [DATA_W-1:0] s1_dt_q, s1_dt_d, s1_jpc_q, s1_jpc_d;
  logic [NICK_W-1:0] q_nick_q [DEPTH];
  logic [NICK_W-1:0] q_nick_d [DEPTH];
  logic [DATA_W-1:0] q_dt_q   [DEPTH];
  logic [DATA_W-1:0] q_dt_d   [DEPTH];
  logic [DATA_W-1:0] q_jpc_q  [DEPTH];
  logic [DATA_W-1:0] q_jpc_d  [DEPTH];
  logic              q_ac_q   [DEPTH];
  logic              q_ac_d   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d, occ;
  logic              ex_en, accept, push, pop;

  // Occupancy counts the op sitting in stage 1 so it always has a queue slot next edge
  assign occ           = count_q + (PTR_W+1)'(s1_valid_q);
  assign bus.oRS_ready = occ < FULL;
  assign ex_en         = count_q != '0;
  assign accept        = bus.iRS_en & bus.oRS_ready & rdy & ~iROB_clr;
  assign push          = s1_valid_q;
  assign pop           = ex_en & bus.iCDB_gnt & rdy;

  assign bus.oEX_en    = ex_en;
  assign bus.oEX_nick  = q_nick_q[rd_ptr_q];
  assign bus.oEX_dt    = q_dt_q[rd_ptr_q];
  assign bus.oEX_ac    = q_ac_q[rd_ptr_q];
  assign bus.oEX_j_pc  = q_jpc_q[rd_ptr_q];

  // Decode and compute the offered op; every field has a default so nothing stale leaks
  always_comb begin
    case (bus.iRS_op)
      `OP_ADDI, `OP_SLTI, `OP_SLTIU, `OP_XORI, `OP_ORI, `OP_ANDI,
      `OP_SLLI, `OP_SRLI, `OP_SRAI: use_imm = 1'b1;
      default:                      use_imm = 1'b0;
    endcase
    opb    = use_imm ? bus.iRS_imm : bus.iRS_rs2_dt;
    shamt  = opb[SH_W-1:0];
    lt_s   = $signed(bus.iRS_rs1_dt) < $signed(opb);
    lt_u   = bus.iRS_rs1_dt < opb;
    eq     = bus.iRS_rs1_dt == opb;
    pc4    = bus.iRS_pc + FOUR;
    pc_imm = bus.iRS_pc + bus.iRS_imm;
    ex_dt  = '0;
    ex_ac  = `NotJump;
    ex_jpc = pc4;
    case (bus.iRS_op)
      `OP_LUI:             ex_dt = bus.iRS_imm;
      `OP_AUIPC:           ex_dt = pc_imm;
      `OP_ADD, `OP_ADDI:   ex_dt = bus.iRS_rs1_dt + opb;
      `OP_SUB:             ex_dt = bus.iRS_rs1_dt - opb;
      `OP_XOR, `OP_XORI:   ex_dt = bus.iRS_rs1_dt ^ opb;
      `OP_OR,  `OP_ORI:    ex_dt = bus.iRS_rs1_dt | opb;
      `OP_AND, `OP_ANDI:   ex_dt = bus.iRS_rs1_dt & opb;
      `OP_SLL, `OP_SLLI:   ex_dt = bus.iRS_rs1_dt << shamt;
      `OP_SRL, `OP_SRLI:   ex_dt = bus.iRS_rs1_dt >> shamt;
      `OP_SRA, `OP_SRAI:   ex_dt = $unsigned($signed(bus.iRS_rs1_dt) >>> shamt);
      `OP_SLT, `OP_SLTI:   ex_dt = DATA_W'(lt_s);
      `OP_SLTU, `OP_SLTIU: ex_dt = DATA_W'(lt_u);
      `OP_BEQ:  begin ex_ac = eq;    ex_jpc = eq    ? pc_imm : pc4; end
      `OP_BNE:  begin ex_ac = ~eq;   ex_jpc = ~eq   ? pc_imm : pc4; end
      `OP_BLT:  begin ex_ac = lt_s;  ex_jpc = lt_s  ? pc_imm : pc4; end
      `OP_BGE:  begin ex_ac = ~lt_s; ex_jpc = ~lt_s ? pc_imm : pc4; end
      `OP_BLTU: begin ex_ac = lt_u;  ex_jpc = lt_u  ? pc_imm : pc4; end
      `OP_BGEU: begin ex_ac = ~lt_u; ex_jpc = ~lt_u ? pc_imm : pc4; end
      `OP_JAL:  begin ex_ac = `Jump; ex_dt = pc4; ex_jpc = pc_imm; end
      `OP_JALR: begin
        ex_ac  = `Jump;
        ex_dt  = pc4;
        ex_jpc = (bus.iRS_rs1_dt + bus.iRS_imm) & ~DATA_W'(1);
      end
      default: ;
    endcase
  end

  // Next state for stage 1 and the circular result queue; flush wins over accept and pop
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_nick_d  = s1_nick_q;
    s1_dt_d    = s1_dt_q;
    s1_ac_d    = s1_ac_q;
    s1_jpc_d   = s1_jpc_q;
    q_nick_d   = q_nick_q;
    q_dt_d     = q_dt_q;
    q_ac_d     = q_ac_q;
    q_jpc_d    = q_jpc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (rdy) begin
      if (iROB_clr) begin
        s1_valid_d = 1'b0;
        count_d    = '0;
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
      end else begin
        if (push) begin
          q_nick_d[wr_ptr_q] = s1_nick_q;
          q_dt_d[wr_ptr_q]   = s1_dt_q;
          q_ac_d[wr_ptr_q]   = s1_ac_q;
          q_jpc_d[wr_ptr_q]  = s1_jpc_q;
          wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) count_d = count_q + (PTR_W+1)'(1);
        if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
        s1_valid_d = accept;
        if (accept) begin
          s1_nick_d = bus.iRS_rd_nick;
          s1_dt_d   = ex_dt;
          s1_ac_d   = ex_ac;
          s1_jpc_d  = ex_jpc;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_nick_q  <= '0;
      s1_dt_q    <= '0;
      s1_ac_q    <= `NotJump;
      s1_jpc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_nick_q[i] <= '0;
        q_dt_q[i]   <= '0;
        q_ac_q[i]   <= `NotJump;
        q_jpc_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_nick_q  <= s1_nick_d;
      s1_dt_q    <= s1_dt_d;
      s1_ac_q    <= s1_ac_d;
      s1_jpc_q   <= s1_jpc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      q_nick_q   <= q_nick_d;
      q_dt_q     <= q_dt_d;
      q_ac_q     <= q_ac_d;
      q_jpc_q    <= q_jpc_d;
    end
  end

  // The ready rule guarantees stage 1 never pushes into a full queue
  assert property (@(posedge clk) disable iff (rst) s1_valid_q |-> (count_q != FULL));
endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed self-checking bench for execute_pipe
`timescale 1ns/1ps
module tb_execute_pipe;
  localparam int DATA_W = 32;
  localparam int NICK_W = 4;
  localparam int OP_W   = 6;
  localparam int DEPTH  = 4;

  localparam logic [5:0] T_LUI = 6'd1,  T_AUIPC = 6'd2,  T_JAL = 6'd3,  T_JALR = 6'd4;
  localparam logic [5:0] T_BEQ = 6'd5,  T_BLT = 6'd7,    T_BLTU = 6'd9, T_ADDI = 6'd19;
  localparam logic [5:0] T_ADD = 6'd28, T_SUB = 6'd29,   T_SLT = 6'd31, T_SLTU = 6'd32;
  localparam logic [5:0] T_SRA = 6'd35, T_UNK = 6'd63;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  execute_pipe_if #(.DATA_W(DATA_W), .NICK_W(NICK_W), .OP_W(OP_W)) bus ();

  execute_pipe #(.DATA_W(DATA_W), .NICK_W(NICK_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [3:0] nick, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.iRS_en      = 1'b1;
    bus.iRS_op      = op;
    bus.iRS_pc      = pc;
    bus.iRS_imm     = imm;
    bus.iRS_rd_nick = nick;
    bus.iRS_rs1_dt  = rs1;
    bus.iRS_rs2_dt  = rs2;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [3:0] nick, input logic [31:0] rs1, input logic [31:0] rs2);
    drive_op(op, pc, imm, nick, rs1, rs2);
    @(negedge clk);
    bus.iRS_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    bus.iCDB_gnt = 1'b1;
    @(negedge clk);
    bus.iCDB_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; clr = 1'b0;
    bus.iRS_en = 1'b0; bus.iCDB_gnt = 1'b0;
    drive_op(T_ADD, 0, 0, 0, 0, 0);
    bus.iRS_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", bus.oEX_en); end
    n_cmp++; if (bus.oRS_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.oRS_ready); end
    n_cmp++; if (bus.oEX_nick !== 4'd0 || bus.oEX_dt !== 32'd0 || bus.oEX_ac !== 1'b0 || bus.oEX_j_pc !== 32'd0) begin
      n_bad++; $display("FAIL reset_fields: got nick=%h dt=%h ac=%b jpc=%h want all 0", bus.oEX_nick, bus.oEX_dt, bus.oEX_ac, bus.oEX_j_pc);
    end
  endtask

  task automatic test_add();
    drive_op(T_ADD, 32'h0, 32'h0, 4'd3, 32'd5, 32'd7);
    @(negedge clk);
    bus.iRS_en = 1'b0;
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL add_not_early: got %b want 0", bus.oEX_en); end
    @(negedge clk);
    n_cmp++; if (bus.oEX_en !== 1'b1) begin n_bad++; $display("FAIL add_en: got %b want 1", bus.oEX_en); end
    n_cmp++; if (bus.oEX_nick !== 4'd3) begin n_bad++; $display("FAIL add_nick: got %0d want 3", bus.oEX_nick); end
    n_cmp++; if (bus.oEX_dt !== 32'd12) begin n_bad++; $display("FAIL add_dt: got %0d want 12", bus.oEX_dt); end
    n_cmp++; if (bus.oEX_ac !== 1'b0 || bus.oEX_j_pc !== 32'h4) begin
      n_bad++; $display("FAIL add_ctl: got ac=%b jpc=%h want ac=0 jpc=4", bus.oEX_ac, bus.oEX_j_pc);
    end
    pop_one();
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL add_popped: got %b want 0", bus.oEX_en); end
  endtask

  task automatic test_alu();
    logic [5:0]  ops [8] = '{T_SRA, T_SLTU, T_SLT, T_SUB, T_ADDI, T_LUI, T_AUIPC, T_UNK};
    logic [31:0] a   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h5};
    logic [31:0] b   [8] = '{32'h21, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h7};
    logic [31:0] imm [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h12345000, 32'h1000, 32'h9};
    logic [31:0] exp [8] = '{32'hC0000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h12345000, 32'h1040, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], 32'h40, imm[i], 4'(i), a[i], b[i]);
      n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oEX_nick !== 4'(i)) begin
        n_bad++; $display("FAIL alu_head[%0d]: got en=%b nick=%0d want en=1 nick=%0d", i, bus.oEX_en, bus.oEX_nick, i);
      end
      n_cmp++; if (bus.oEX_dt !== exp[i]) begin
        n_bad++; $display("FAIL alu_dt[%0d]: got %h want %h", i, bus.oEX_dt, exp[i]);
      end
      n_cmp++; if (bus.oEX_ac !== 1'b0 || bus.oEX_j_pc !== 32'h44) begin
        n_bad++; $display("FAIL alu_ctl[%0d]: got ac=%b jpc=%h want ac=0 jpc=44", i, bus.oEX_ac, bus.oEX_j_pc);
      end
      pop_one();
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [6] = '{T_BEQ, T_BEQ, T_BLT, T_BLTU, T_JALR, T_JAL};
    logic [31:0] pc  [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h200};
    logic [31:0] imm [6] = '{32'h20, 32'h20, 32'hFFFFFFF8, 32'h20, 32'h0, 32'h7FC};
    logic [31:0] a   [6] = '{32'h9, 32'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h301, 32'h0};
    logic [31:0] b   [6] = '{32'h9, 32'h8, 32'h1, 32'h1, 32'h0, 32'h0};
    logic [31:0] edt [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h204, 32'h204};
    logic        eac [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ejp [6] = '{32'h120, 32'h104, 32'hF8, 32'h104, 32'h300, 32'h9FC};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], pc[i], imm[i], 4'(i + 8), a[i], b[i]);
      n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oEX_dt !== edt[i]) begin
        n_bad++; $display("FAIL br_dt[%0d]: got en=%b dt=%h want en=1 dt=%h", i, bus.oEX_en, bus.oEX_dt, edt[i]);
      end
      n_cmp++; if (bus.oEX_ac !== eac[i]) begin
        n_bad++; $display("FAIL br_ac[%0d]: got %b want %b", i, bus.oEX_ac, eac[i]);
      end
      n_cmp++; if (bus.oEX_j_pc !== ejp[i]) begin
        n_bad++; $display("FAIL br_jpc[%0d]: got %h want %h", i, bus.oEX_j_pc, ejp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back();
    int   acc = 0;
    int   outn = 0;
    int   cyc = 0;
    logic took;
    bus.iCDB_gnt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) drive_op(T_ADDI, 0, 32'd1, 4'(acc), 32'(acc * 10), 0);
      else bus.iRS_en = 1'b0;
      took = bus.iRS_en && bus.oRS_ready;
      @(negedge clk);
      if (took) acc++;
    end
    n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL b2b_fill: got %0d accepted want 4", acc); end
    n_cmp++; if (bus.oRS_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b want 0", bus.oRS_ready); end
    bus.iCDB_gnt = 1'b1;
    while (outn < 6 && cyc < 40) begin
      if (acc < 6) drive_op(T_ADDI, 0, 32'd1, 4'(acc), 32'(acc * 10), 0);
      else bus.iRS_en = 1'b0;
      took = bus.iRS_en && bus.oRS_ready;
      if (bus.oEX_en === 1'b1) begin
        n_cmp++; if (bus.oEX_nick !== 4'(outn) || bus.oEX_dt !== 32'(outn * 10 + 1)) begin
          n_bad++; $display("FAIL b2b_order[%0d]: got nick=%0d dt=%0d want nick=%0d dt=%0d", outn, bus.oEX_nick, bus.oEX_dt, outn, outn * 10 + 1);
        end
        outn++;
      end
      @(negedge clk);
      cyc++;
      if (took) acc++;
    end
    bus.iCDB_gnt = 1'b0;
    bus.iRS_en = 1'b0;
    n_cmp++; if (outn != 6 || acc != 6) begin
      n_bad++; $display("FAIL b2b_drain: got out=%0d acc=%0d want 6/6 within budget", outn, acc);
    end
  endtask

  task automatic test_flush();
    bus.iCDB_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_op(T_ADD, 0, 0, 4'(i), 32'(i), 32'd1);
      @(negedge clk);
    end
    n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oRS_ready !== 1'b0 || bus.oEX_nick !== 4'd0) begin
      n_bad++; $display("FAIL flush_pre: got en=%b ready=%b nick=%0d want 1/0/0", bus.oEX_en, bus.oRS_ready, bus.oEX_nick);
    end
    clr = 1'b1; bus.iCDB_gnt = 1'b1;
    drive_op(T_ADD, 0, 0, 4'd15, 32'd1, 32'd1);
    @(negedge clk);
    clr = 1'b0; bus.iCDB_gnt = 1'b0; bus.iRS_en = 1'b0;
    n_cmp++; if (bus.oEX_en !== 1'b0 || bus.oRS_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_post: got en=%b ready=%b want 0/1", bus.oEX_en, bus.oRS_ready);
    end
    @(negedge clk);
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL flush_s1: got en=%b want 0", bus.oEX_en); end
    run_op(T_ADD, 0, 0, 4'd9, 32'd100, 32'd23);
    n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oEX_nick !== 4'd9 || bus.oEX_dt !== 32'd123) begin
      n_bad++; $display("FAIL flush_fresh: got en=%b nick=%0d dt=%0d want 1/9/123", bus.oEX_en, bus.oEX_nick, bus.oEX_dt);
    end
    pop_one();
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL flush_alone: got en=%b want 0", bus.oEX_en); end
  endtask

  task automatic test_rdy_hold();
    run_op(T_ADDI, 0, 32'd0, 4'd5, 32'd50, 0);
    rdy = 1'b0; bus.iCDB_gnt = 1'b1;
    drive_op(T_ADDI, 0, 32'd0, 4'd6, 32'd60, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oEX_nick !== 4'd5 || bus.oEX_dt !== 32'd50 || bus.oRS_ready !== 1'b1) begin
        n_bad++; $display("FAIL rdy_hold[%0d]: got en=%b nick=%0d dt=%0d ready=%b want 1/5/50/1", i, bus.oEX_en, bus.oEX_nick, bus.oEX_dt, bus.oRS_ready);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    bus.iRS_en = 1'b0; bus.iCDB_gnt = 1'b0;
    n_cmp++; if (bus.oEX_en !== 1'b0) begin n_bad++; $display("FAIL rdy_resume_pop: got en=%b want 0", bus.oEX_en); end
    @(negedge clk);
    n_cmp++; if (bus.oEX_en !== 1'b1 || bus.oEX_nick !== 4'd6 || bus.oEX_dt !== 32'd60) begin
      n_bad++; $display("FAIL rdy_resume_acc: got en=%b nick=%0d dt=%0d want 1/6/60", bus.oEX_en, bus.oEX_nick, bus.oEX_dt);
    end
    pop_one();
  endtask

  task automatic test_reset_override();
    run_op(T_ADDI, 0, 32'd0, 4'd7, 32'd77, 0);
    rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    n_cmp++; if (bus.oEX_en !== 1'b0 || bus.oEX_nick !== 4'd0 || bus.oEX_dt !== 32'd0 || bus.oRS_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_override: got en=%b nick=%0d dt=%0d ready=%b want 0/0/0/1", bus.oEX_en, bus.oEX_nick, bus.oEX_dt, bus.oRS_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_branch();
    test_back_to_back();
    test_flush();
    test_rdy_hold();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised successor to the single-cycle integer execute unit.
- Accepts one ALU/branch/jump op per cycle from the RS and computes it in one registered stage.
- Buffers results in a DEPTH-entry result queue so the CDB arbiter may stall the unit.
- Supports a misprediction flush; the RS sees backpressure through a ready signal.

Parameters:
- DATA_W, 32, datapath and address width.
- NICK_W, 4, ROB tag (nick) width.
- OP_W, 6, op-code width; encodings come from the config.v op macros.
- DEPTH, 4, result queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- iROB_clr  in  1  flush: discard all in-flight and queued results.
- iRS_en  in  1  op valid from RS.
- oRS_ready  out  1  unit can accept an op this cycle.
- iRS_pc  in  DATA_W  instruction pc.
- iRS_op  in  OP_W  op code.
- iRS_imm  in  DATA_W  sign-extended immediate.
- iRS_rd_nick  in  NICK_W  destination ROB tag.
- iRS_rs1_dt  in  DATA_W  rs1 operand.
- iRS_rs2_dt  in  DATA_W  rs2 operand.
- oEX_en  out  1  queue head valid on the CDB.
- iCDB_gnt  in  1  CDB accepted the head this cycle.
- oEX_nick  out  NICK_W  head tag.
- oEX_dt  out  DATA_W  head result data.
- oEX_ac  out  1  head actual branch outcome (`Jump/`NotJump).
- oEX_j_pc  out  DATA_W  head resolved next pc.

Behaviour:
- Reset (rst=1 at posedge): stage-1 valid=0, queue count=0, read/write pointers=0, oEX_en=0. oEX_nick/dt/ac/j_pc=0. rst overrides rdy and iROB_clr.
- rdy=0: no state changes, no accept, no pop. Outputs hold.
- Accept: the op is taken when iRS_en & oRS_ready & rdy & ~iROB_clr.
- oRS_ready = (count + s1_valid) < DEPTH. This is conservative: a same-cycle pop does not raise ready.
- Latency:
  - An op accepted at edge N is computed into stage 1 at edge N.
  - It is written to the queue at edge N+1.
  - It is visible on oEX_* from cycle N+1 when the queue was empty and there is no pop conflict.
- Queue: circular buffer with a count register.
  - Push = s1_valid. Pop = oEX_en & iCDB_gnt & rdy.
  - Simultaneous push+pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
  - oEX_* are the head entry, combinational from the queue. oEX_en = (count != 0).
  - Push when full cannot happen by the ready rule; an assertion checks this.
- Flush (iROB_clr & rdy): clears s1_valid, count and pointers in that cycle. Same-cycle accept and pop are ignored. oEX_en=0 from the next cycle.
- Compute rules (all results DATA_W, wrap-around arithmetic):
  - LUI: dt=imm. AUIPC: dt=pc+imm.
  - ADD/ADDI: add. SUB: subtract. XOR/OR/AND and their I-forms: bitwise.
  - SLL/SRL/SRA and their I-forms: shift amount = low $clog2(DATA_W) bits of rs2/imm. SRA/SRAI are arithmetic (sign fill).
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Result zero-extended 0/1.
  - Branches BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU (unsigned):
    - taken: ac=`Jump, j_pc=pc+imm.
    - not taken: ac=`NotJump, j_pc=pc+4.
    - dt=0 in both cases.
  - JAL: ac=`Jump, dt=pc+4, j_pc=pc+imm.
  - JALR: ac=`Jump, dt=pc+4, j_pc=(rs1+imm) & ~1.
  - All non-control ops: ac=`NotJump, j_pc=pc+4.
  - Unknown op: dt=0, ac=`NotJump, j_pc=pc+4. The entry is still queued so the ROB entry completes.
- Every field is assigned for every op; no latch or stale value leaks between entries.

Test Plan:
- Reset, then ADD rs1=5 rs2=7 nick=3 → oEX_en=1 one cycle after accept, nick=3, dt=12, ac=NotJump. iCDB_gnt=1 gives oEX_en=0 next cycle.
- SRA rs1=0x80000000 rs2=0x21 → dt=0xC0000000 (shamt 1). SLTU rs1=0xFFFFFFFF rs2=1 → dt=0. SLT same operands → dt=1.
- BEQ pc=0x100 imm=0x20, operands equal → ac=Jump, j_pc=0x120. Operands unequal → ac=NotJump, j_pc=0x104. JALR pc=0x200 rs1=0x301 imm=0 → dt=0x204, j_pc=0x300.
- iCDB_gnt held 0 and 6 ops offered back-to-back, DEPTH=4 → oRS_ready falls after 4 accepts. Then grant 1 each cycle → results leave in order with nicks 0,1,2,3, then remaining ops accepted.
- Queue holds 3 entries and stage 1 is valid; assert iROB_clr → next cycle oEX_en=0, oRS_ready=1. A fresh op then appears alone with the correct result.
- rdy=0 for 3 cycles with iCDB_gnt=1 and iRS_en=1 → no pop, no accept, outputs stable. rdy=1 resumes exactly where it stopped.
